// File: rtl/erm16_io_port.sv
// ERM16 memory-mapped I/O port: decodes core bus strobes into a TX FIFO,
// an RX FIFO, status/level/interrupt-enable registers and a level interrupt.
module erm16_io_port #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        wrmem,
    input  logic        ioe,
    output logic [15:0] rdata,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [15:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Handshakes: a word moves on every rising clk edge where valid & ready
    // are both high; valid never depends on ready, and both drop during rst.

    logic          ioe_d_q, ioe_d_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          irq_q, irq_d;
    logic [1:0]    ie_q, ie_d;
    logic          tx_ovf_q, tx_ovf_d;
    logic          rx_unf_q, rx_unf_d;

    logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [15:0]   tx_mem_q [DEPTH];
    logic [15:0]   tx_mem_d [DEPTH];
    logic [15:0]   rx_mem_q [DEPTH];
    logic [15:0]   rx_mem_d [DEPTH];

    logic          stb;
    logic          tx_empty, tx_full, rx_empty, rx_full;
    logic          tx_push, tx_pop, rx_push, rx_pop;
    logic          wr_data, rd_data, wr_status, wr_ie;
    logic [15:0]   status_val, level_val;
    logic          unused_ok;

    assign unused_ok = ^addr[15:2];

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == CW'(DEPTH));
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CW'(DEPTH));

    assign tx_data  = tx_mem_q[tx_rp_q];
    assign tx_valid = ~rst & ~tx_empty;
    assign rx_ready = ~rst & ~rx_full;
    assign rdata    = rdata_q;
    assign irq      = irq_q;

    assign status_val = {10'b0, rx_unf_q, tx_ovf_q, rx_full, rx_empty, tx_full, tx_empty};
    assign level_val  = {8'(tx_cnt_q), 8'(rx_cnt_q)};

    always_comb begin
        ioe_d_d   = ioe;
        stb       = ioe & ~ioe_d_q;
        wr_data   = stb & wrmem & (addr[1:0] == 2'd0);
        rd_data   = stb & ~wrmem & (addr[1:0] == 2'd0);
        wr_status = stb & wrmem & (addr[1:0] == 2'd1);
        wr_ie     = stb & wrmem & (addr[1:0] == 2'd3);

        // A pop frees the slot in the same cycle, so a push into a full FIFO is legal then.
        tx_pop  = tx_valid & tx_ready;
        tx_push = wr_data & (~tx_full | tx_pop);
        rx_push = rx_valid & rx_ready;
        rx_pop  = rd_data & ~rx_empty;

        tx_mem_d = tx_mem_q;
        tx_wp_d  = tx_wp_q;
        tx_rp_d  = tx_rp_q;
        tx_cnt_d = tx_cnt_q;
        if (tx_push) begin
            tx_mem_d[tx_wp_q] = wdata;
            tx_wp_d = tx_wp_q + AW'(1);
        end
        if (tx_pop) begin
            tx_rp_d = tx_rp_q + AW'(1);
        end
        if (tx_push & ~tx_pop) begin
            tx_cnt_d = tx_cnt_q + CW'(1);
        end else if (tx_pop & ~tx_push) begin
            tx_cnt_d = tx_cnt_q - CW'(1);
        end

        rx_mem_d = rx_mem_q;
        rx_wp_d  = rx_wp_q;
        rx_rp_d  = rx_rp_q;
        rx_cnt_d = rx_cnt_q;
        if (rx_push) begin
            rx_mem_d[rx_wp_q] = rx_data;
            rx_wp_d = rx_wp_q + AW'(1);
        end
        if (rx_pop) begin
            rx_rp_d = rx_rp_q + AW'(1);
        end
        if (rx_push & ~rx_pop) begin
            rx_cnt_d = rx_cnt_q + CW'(1);
        end else if (rx_pop & ~rx_push) begin
            rx_cnt_d = rx_cnt_q - CW'(1);
        end

        // Sticky flags: a same-cycle set overrides the write-1-to-clear.
        tx_ovf_d = (wr_data & tx_full & ~tx_pop)
                 | (tx_ovf_q & ~(wr_status & wdata[4]));
        rx_unf_d = (rd_data & rx_empty)
                 | (rx_unf_q & ~(wr_status & wdata[5]));

        ie_d = wr_ie ? wdata[1:0] : ie_q;

        rdata_d = rdata_q;
        if (stb & ~wrmem) begin
            case (addr[1:0])
                2'd0:    rdata_d = rx_empty ? 16'h0000 : rx_mem_q[rx_rp_q];
                2'd1:    rdata_d = status_val;
                2'd2:    rdata_d = level_val;
                default: rdata_d = {14'b0, ie_q};
            endcase
        end

        irq_d = (ie_d[0] & (rx_cnt_d != '0)) | (ie_d[1] & (tx_cnt_d == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ioe_d_q  <= 1'b0;
            rdata_q  <= 16'h0000;
            irq_q    <= 1'b0;
            ie_q     <= 2'b00;
            tx_ovf_q <= 1'b0;
            rx_unf_q <= 1'b0;
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            ioe_d_q  <= ioe_d_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
            ie_q     <= ie_d;
            tx_ovf_q <= tx_ovf_d;
            rx_unf_q <= rx_unf_d;
            tx_wp_q  <= tx_wp_d;
            tx_rp_q  <= tx_rp_d;
            tx_cnt_q <= tx_cnt_d;
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end

    // Storage needs no reset: entries are only visible through valid counts.
    always_ff @(posedge clk) begin
        tx_mem_q <= tx_mem_d;
        rx_mem_q <= rx_mem_d;
    end

endmodule

// File: tb/tb_erm16_io_port.sv
// Directed, table-driven bench for erm16_io_port: register-map vectors plus
// hand-written sequences for strobe, FIFO boundary, irq and reset behaviour.
module tb_erm16_io_port;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr, wdata, rdata, tx_data, rx_data;
    logic        wrmem, ioe, tx_valid, tx_ready, rx_valid, rx_ready, irq;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        bit          wr;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] exp;
        string       name;
    } vec_t;
    vec_t vq[$];

    erm16_io_port #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wrmem(wrmem),
        .ioe(ioe), .rdata(rdata), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic io_wr(input logic [15:0] a, input logic [15:0] d);
        ioe = 1'b1; wrmem = 1'b1; addr = a; wdata = d;
        tick();
        ioe = 1'b0; wrmem = 1'b0;
        tick();
    endtask

    task automatic rd_chk(input string name, input logic [15:0] a, input logic [15:0] exp);
        ioe = 1'b1; wrmem = 1'b0; addr = a;
        tick();
        chk(name, rdata, exp);
        ioe = 1'b0;
        tick();
    endtask

    task automatic rx_push1(input logic [15:0] d);
        rx_valid = 1'b1; rx_data = d;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic add_vec(input bit wr, input logic [15:0] a, input logic [15:0] d,
                           input logic [15:0] exp, input string name);
        vec_t v;
        v.wr = wr; v.a = a; v.d = d; v.exp = exp; v.name = name;
        vq.push_back(v);
    endtask

    task automatic drain_tx();
        tx_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (!tx_valid) break;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL tx_extra: got 0x%04h, expected no word", tx_data);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (tx_data !== e) begin
                    n_fail++;
                    $display("FAIL tx_data: got 0x%04h, expected 0x%04h", tx_data, e);
                end
            end
            tick();
        end
        tx_ready = 1'b0;
        chk("tx_drain_valid", {15'b0, tx_valid}, 16'h0000);
        chk("tx_drain_left", 16'(exp_q.size()), 16'h0000);
    endtask

    initial begin
        int k;
        logic acc;
        rst = 1'b1; ioe = 1'b0; wrmem = 1'b0; addr = '0; wdata = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (3) tick();
        chk("rst_tx_valid", {15'b0, tx_valid}, 16'h0000);
        chk("rst_rx_ready", {15'b0, rx_ready}, 16'h0000);
        rst = 1'b0;
        tick();
        chk("rst_rdata", rdata, 16'h0000);
        chk("rst_irq", {15'b0, irq}, 16'h0000);
        chk("post_rst_rx_ready", {15'b0, rx_ready}, 16'h0001);

        // Register-map table
        add_vec(0, 16'h0001, 16'h0000, 16'h0005, "status_rst");
        add_vec(0, 16'h0002, 16'h0000, 16'h0000, "level_rst");
        add_vec(0, 16'h0003, 16'h0000, 16'h0000, "ie_rst");
        add_vec(1, 16'h0003, 16'hFFFF, 16'h0000, "");
        add_vec(0, 16'h0003, 16'h0000, 16'h0003, "ie_rw");
        add_vec(1, 16'h0003, 16'h0000, 16'h0000, "");
        add_vec(0, 16'hFFF7, 16'h0000, 16'h0000, "ie_alias");
        add_vec(1, 16'h0002, 16'hFFFF, 16'h0000, "");
        add_vec(0, 16'h0002, 16'h0000, 16'h0000, "level_ro");
        add_vec(1, 16'h0000, 16'h1234, 16'h0000, "");
        add_vec(1, 16'h8000, 16'hABCD, 16'h0000, "");
        add_vec(0, 16'h0002, 16'h0000, 16'h0200, "level_tx2");
        add_vec(0, 16'h0005, 16'h0000, 16'h0004, "status_alias");
        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].wr) begin
                io_wr(vq[i].a, vq[i].d);
                if (vq[i].a[1:0] == 2'd0) exp_q.push_back(vq[i].d);
            end else begin
                rd_chk(vq[i].name, vq[i].a, vq[i].exp);
            end
        end
        chk("rdata_hold_after_wr", rdata, 16'h0004);
        drain_tx();

        // ioe held high for 4 cycles: exactly one push
        ioe = 1'b1; wrmem = 1'b1; addr = 16'h0000; wdata = 16'h5555;
        repeat (4) tick();
        ioe = 1'b0; wrmem = 1'b0;
        tick();
        exp_q.push_back(16'h5555);
        rd_chk("level_hold", 16'h0002, 16'h0100);
        drain_tx();

        // Fill TX, overflow, W1C
        for (int i = 0; i < 8; i++) begin
            io_wr(16'h0000, 16'h0100 + 16'(i * 17));
            exp_q.push_back(16'h0100 + 16'(i * 17));
        end
        rd_chk("level_tx_full", 16'h0002, 16'h0800);
        io_wr(16'h0000, 16'hDEAD);
        rd_chk("status_ovf", 16'h0001, 16'h0016);
        io_wr(16'h0001, 16'h0010);
        rd_chk("status_ovf_clr", 16'h0001, 16'h0006);

        // Full TX: write and pop in the same cycle
        ioe = 1'b1; wrmem = 1'b1; addr = 16'h0000; wdata = 16'h7777; tx_ready = 1'b1;
        chk("full_pop_valid", {15'b0, tx_valid}, 16'h0001);
        chk("full_pop_head", tx_data, exp_q.pop_front());
        tick();
        tx_ready = 1'b0; ioe = 1'b0; wrmem = 1'b0;
        exp_q.push_back(16'h7777);
        tick();
        rd_chk("level_full_pop", 16'h0002, 16'h0800);
        rd_chk("status_full_pop", 16'h0001, 16'h0006);
        drain_tx();
        rd_chk("status_tx_drained", 16'h0001, 16'h0005);

        // RX underflow and rx_ne interrupt
        rd_chk("rx_empty_read", 16'h0000, 16'h0000);
        rd_chk("status_unf", 16'h0001, 16'h0025);
        io_wr(16'h0003, 16'h0001);
        chk("irq_ie1_empty", {15'b0, irq}, 16'h0000);
        rx_push1(16'h00FF);
        chk("irq_rx_ne", {15'b0, irq}, 16'h0001);
        rd_chk("rx_read_ff", 16'h0000, 16'h00FF);
        chk("irq_after_pop", {15'b0, irq}, 16'h0000);
        io_wr(16'h0001, 16'h0020);
        rd_chk("status_unf_clr", 16'h0001, 16'h0005);
        io_wr(16'h0003, 16'h0000);

        // Same-cycle peripheral push with a DATA read (non-empty, then empty)
        rx_push1(16'h0A0A);
        ioe = 1'b1; wrmem = 1'b0; addr = 16'h0000; rx_valid = 1'b1; rx_data = 16'h0B0B;
        tick();
        chk("rx_pushpop_data", rdata, 16'h0A0A);
        rx_valid = 1'b0; ioe = 1'b0;
        tick();
        rd_chk("level_pushpop", 16'h0002, 16'h0001);
        rd_chk("rx_read_0b", 16'h0000, 16'h0B0B);
        ioe = 1'b1; wrmem = 1'b0; addr = 16'h0000; rx_valid = 1'b1; rx_data = 16'h0C0C;
        tick();
        chk("rx_empty_push_data", rdata, 16'h0000);
        rx_valid = 1'b0; ioe = 1'b0;
        tick();
        rd_chk("rx_read_0c", 16'h0000, 16'h0C0C);
        io_wr(16'h0001, 16'h0020);
        rd_chk("status_clr2", 16'h0001, 16'h0005);

        // Fill RX until ready drops
        k = 0;
        rx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rx_data = 16'hC000 + 16'(k);
            acc = rx_ready;
            tick();
            if (acc) k++;
        end
        rx_valid = 1'b0;
        chk("rx_accepted", 16'(k), 16'h0008);
        rd_chk("status_rx_full", 16'h0001, 16'h0009);
        rd_chk("level_rx_full", 16'h0002, 16'h0008);
        for (int j = 0; j < 8; j++) rd_chk("rx_fill_read", 16'h0000, 16'hC000 + 16'(j));
        rd_chk("status_rx_drained", 16'h0001, 16'h0005);

        // tx_empty interrupt
        io_wr(16'h0003, 16'h0002);
        chk("irq_tx_e", {15'b0, irq}, 16'h0001);
        io_wr(16'h0000, 16'h4242);
        exp_q.push_back(16'h4242);
        chk("irq_tx_ne", {15'b0, irq}, 16'h0000);
        drain_tx();
        chk("irq_tx_e_again", {15'b0, irq}, 16'h0001);
        io_wr(16'h0003, 16'h0000);
        chk("irq_ie_off", {15'b0, irq}, 16'h0000);

        // Memory cycles have no effect
        ioe = 1'b0; wrmem = 1'b1; addr = 16'h0000; wdata = 16'h9999;
        repeat (2) tick();
        wrmem = 1'b0;
        chk("mem_cycle_tx_valid", {15'b0, tx_valid}, 16'h0000);
        rd_chk("level_mem_cycle", 16'h0002, 16'h0000);

        // Reset mid-operation
        io_wr(16'h0000, 16'h1111);
        rx_push1(16'h2222);
        rd_chk("level_pre_rst", 16'h0002, 16'h0101);
        rst = 1'b1;
        tick();
        chk("midrst_tx_valid", {15'b0, tx_valid}, 16'h0000);
        chk("midrst_rx_ready", {15'b0, rx_ready}, 16'h0000);
        rst = 1'b0;
        tick();
        chk("midrst_rdata", rdata, 16'h0000);
        chk("midrst_tx_valid_after", {15'b0, tx_valid}, 16'h0000);
        rd_chk("midrst_level", 16'h0002, 16'h0000);
        rd_chk("midrst_status", 16'h0001, 16'h0005);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
